// File: rtl/serial_paralelo_multilane_if.sv
// Bus between the serial link receivers and the multilane deserialiser:
// serial bits in, per-lane parallel words and lane status out.
interface serial_paralelo_multilane_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 1
);
  logic                   realign;
  logic [LANES-1:0]       data_in_SP;
  logic [LANES*WIDTH-1:0] data_out_SP;
  logic [LANES-1:0]       valid_SP;
  logic [LANES-1:0]       active;
  logic                   all_active;

  modport master (
    output realign, data_in_SP,
    input  data_out_SP, valid_SP, active, all_active
  );

  modport slave (
    input  realign, data_in_SP,
    output data_out_SP, valid_SP, active, all_active
  );
endinterface

// File: rtl/serial_paralelo_multilane.sv
// Multilane MSB-first serial-to-parallel converter with per-lane comma alignment,
// lock after LOCK_COMMAS aligned commas and loss after LOSS_COMMAS misaligned ones.
module serial_paralelo_multilane #(
  parameter int               WIDTH       = 8,
  parameter int               LANES       = 1,
  parameter logic [WIDTH-1:0] COMMA       = WIDTH'(8'hBC),
  parameter int               LOCK_COMMAS = 4,
  parameter int               LOSS_COMMAS = 2
) (
  input  logic                          clk_32f,
  input  logic                          reset_L,
  serial_paralelo_multilane_if.slave    bus
);
  localparam int CW  = $clog2(WIDTH);
  localparam int CCW = $clog2(LOCK_COMMAS + 1);
  localparam int ECW = $clog2(LOSS_COMMAS + 1);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [CCW-1:0] LOCK_LAST = CCW'(LOCK_COMMAS - 1);
  localparam logic [ECW-1:0] LOSS_LAST = ECW'(LOSS_COMMAS - 1);

  typedef enum logic [1:0] {HUNT = 2'd0, ALIGN = 2'd1, LOCKED = 2'd2} state_t;

  state_t           st_p0   [LANES];
  state_t           st_d    [LANES];
  logic [WIDTH-2:0] sr_p0   [LANES];
  logic [CW-1:0]    cnt_p0  [LANES];
  logic [CW-1:0]    cnt_d   [LANES];
  logic [CCW-1:0]   ccnt_p0 [LANES];
  logic [CCW-1:0]   ccnt_d  [LANES];
  logic [ECW-1:0]   ecnt_p0 [LANES];
  logic [ECW-1:0]   ecnt_d  [LANES];
  logic [WIDTH-1:0] dout_p0 [LANES];
  logic [WIDTH-1:0] dout_d  [LANES];
  logic             vld_p0  [LANES];
  logic             vld_d   [LANES];
  logic             act_p0  [LANES];
  logic             act_d   [LANES];
  logic [WIDTH-1:0] win     [LANES];
  logic             comma   [LANES];
  logic             bnd     [LANES];

  logic [LANES*WIDTH-1:0] dout_vec;
  logic [LANES-1:0]       vld_vec;
  logic [LANES-1:0]       act_vec;
  logic                   all_act_p1;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      win[i]    = {sr_p0[i], bus.data_in_SP[i]};
      comma[i]  = (win[i] == COMMA);
      bnd[i]    = (cnt_p0[i] == CNT_LAST);
      st_d[i]   = st_p0[i];
      cnt_d[i]  = cnt_p0[i];
      ccnt_d[i] = ccnt_p0[i];
      ecnt_d[i] = ecnt_p0[i];
      dout_d[i] = dout_p0[i];
      vld_d[i]  = vld_p0[i];
      act_d[i]  = act_p0[i];

      // realign wins over any boundary or comma seen on the same edge
      if (bus.realign) begin
        st_d[i]   = HUNT;
        cnt_d[i]  = '0;
        ccnt_d[i] = '0;
        ecnt_d[i] = '0;
        vld_d[i]  = 1'b0;
        act_d[i]  = 1'b0;
      end else begin
        case (st_p0[i])
          HUNT: begin
            if (comma[i]) begin
              cnt_d[i]  = '0;
              ccnt_d[i] = CCW'(1);
              if (LOCK_COMMAS == 1) begin
                st_d[i]   = LOCKED;
                act_d[i]  = 1'b1;
                ecnt_d[i] = '0;
              end else begin
                st_d[i] = ALIGN;
              end
            end
          end
          ALIGN: begin
            cnt_d[i] = bnd[i] ? '0 : cnt_p0[i] + CW'(1);
            if (bnd[i]) begin
              if (comma[i]) begin
                ccnt_d[i] = ccnt_p0[i] + CCW'(1);
                if (ccnt_p0[i] == LOCK_LAST) begin
                  st_d[i]   = LOCKED;
                  act_d[i]  = 1'b1;
                  ecnt_d[i] = '0;
                end
              end else begin
                st_d[i]   = HUNT;
                ccnt_d[i] = '0;
              end
            end
          end
          LOCKED: begin
            cnt_d[i] = bnd[i] ? '0 : cnt_p0[i] + CW'(1);
            if (bnd[i]) begin
              dout_d[i] = win[i];
              vld_d[i]  = !comma[i];
              if (comma[i]) ecnt_d[i] = '0;
            end else if (comma[i]) begin
              // a comma off the word boundary means the lane has slipped
              if (ecnt_p0[i] == LOSS_LAST) begin
                st_d[i]   = HUNT;
                act_d[i]  = 1'b0;
                vld_d[i]  = 1'b0;
                ccnt_d[i] = '0;
                ecnt_d[i] = '0;
                cnt_d[i]  = '0;
              end else begin
                ecnt_d[i] = ecnt_p0[i] + ECW'(1);
              end
            end
          end
          default: begin
            st_d[i] = HUNT;
          end
        endcase
      end
    end
  end

  // ---- lane register stage p0 ----
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < LANES; i++) begin
        st_p0[i]   <= HUNT;
        sr_p0[i]   <= '0;
        cnt_p0[i]  <= '0;
        ccnt_p0[i] <= '0;
        ecnt_p0[i] <= '0;
        dout_p0[i] <= '0;
        vld_p0[i]  <= 1'b0;
        act_p0[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        st_p0[i]   <= st_d[i];
        sr_p0[i]   <= win[i][WIDTH-2:0];
        cnt_p0[i]  <= cnt_d[i];
        ccnt_p0[i] <= ccnt_d[i];
        ecnt_p0[i] <= ecnt_d[i];
        dout_p0[i] <= dout_d[i];
        vld_p0[i]  <= vld_d[i];
        act_p0[i]  <= act_d[i];
      end
    end
  end

  always_comb begin
    dout_vec = '0;
    vld_vec  = '0;
    act_vec  = '0;
    for (int i = 0; i < LANES; i++) begin
      dout_vec[i*WIDTH +: WIDTH] = dout_p0[i];
      vld_vec[i]                 = vld_p0[i];
      act_vec[i]                 = act_p0[i];
    end
  end

  // ---- aggregate status stage p1 ----
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L)        all_act_p1 <= 1'b0;
    else if (bus.realign) all_act_p1 <= 1'b0;
    else                 all_act_p1 <= &act_vec;
  end

  assign bus.data_out_SP = dout_vec;
  assign bus.valid_SP    = vld_vec;
  assign bus.active      = act_vec;
  assign bus.all_active  = all_act_p1;
endmodule
